// File: rtl/ifstage_prefetch_pkg.sv
// Shared fetch-stage definitions: word width, PC step, reset PC and the fetch FSM states.
package ifstage_prefetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ENTRY_W = 2 * INSTR_W;

    localparam logic [INSTR_W-1:0] PC_INC           = 32'd4;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DROP
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return {addr[INSTR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifstage_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/ack, decode handshake and redirect.
interface ifstage_prefetch_if;
    import ifstage_prefetch_pkg::*;

    logic               IMem_Req;
    logic [INSTR_W-1:0] IMem_Addr;
    logic               IMem_Ack;
    logic [INSTR_W-1:0] IMem_Data;
    logic [INSTR_W-1:0] Instr;
    logic [INSTR_W-1:0] Instr_PC;
    logic               Instr_Valid;
    logic               Instr_Ready;
    logic               Redirect;
    logic [INSTR_W-1:0] Redirect_Target;

    modport master (
        output IMem_Req, IMem_Addr, Instr, Instr_PC, Instr_Valid,
        input  IMem_Ack, IMem_Data, Instr_Ready, Redirect, Redirect_Target
    );

    modport slave (
        input  IMem_Req, IMem_Addr, Instr, Instr_PC, Instr_Valid,
        output IMem_Ack, IMem_Data, Instr_Ready, Redirect, Redirect_Target
    );

endinterface

// File: rtl/ifstage_prefetch_instr_fifo.sv
// DEPTH-entry FIFO of {PC, Instr} words with flush; push and pop may coincide even when full.
module instr_fifo
    import ifstage_prefetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [ENTRY_W-1:0]         head_data,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [ENTRY_W-1:0] head_reg, head_next;
    logic               valid_reg;
    logic               do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && (count_reg != '0) && !flush;
    assign do_push = push && !flush && ((count_reg != CNT_W'(DEPTH)) || do_pop);

    // The head is kept in its own register so the outputs never come from a read mux.
    always_comb begin
        rd_ptr_next = do_pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        wr_ptr_next = do_push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        head_next   = head_reg;
        if (!flush && (count_next != '0)) begin
            if ((count_reg == '0) || ((count_reg == CNT_W'(1)) && do_pop)) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            valid_reg  <= (count_next != '0);
        end
    end

    assign head_data  = head_reg;
    assign head_valid = valid_reg;
    assign count      = count_reg;

endmodule

// File: rtl/ifstage_prefetch.sv
// Instruction fetch stage: PC and fetch FSM driving instruction memory, feeding a small prefetch queue.
module ifstage_prefetch
    import ifstage_prefetch_pkg::*;
#(
    parameter int                 DEPTH    = 2,
    parameter logic [INSTR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ifstage_prefetch_if.master   bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e       state_reg;
    logic [INSTR_W-1:0] pc_reg;
    logic [INSTR_W-1:0] addr_reg;
    logic               req_reg;
    logic [INSTR_W-1:0] pc_inc;
    logic               push;
    logic               pop;
    logic               room_next;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     count_next;
    logic [ENTRY_W-1:0] head_data;
    logic               head_valid;

    // In FETCH the PC is the outstanding address, so it tags the pushed word.
    assign push       = (state_reg == ST_FETCH) && bus.IMem_Ack && !bus.Redirect;
    assign pop        = head_valid && bus.Instr_Ready;
    assign count_next = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign room_next  = count_next < (CNT_W+1)'(DEPTH);
    assign pc_inc     = pc_reg + PC_INC;

    instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (Clk),
        .srst       (Reset),
        .push       (push),
        .push_data  ({pc_reg, bus.IMem_Data}),
        .pop        (pop),
        .flush      (bus.Redirect),
        .head_data  (head_data),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    // A redirect leaves addr_reg alone so a request turned into DROP keeps its address.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= '0;
            req_reg   <= 1'b0;
        end else if (bus.Redirect) begin
            pc_reg <= word_align(bus.Redirect_Target);
            if (state_reg != ST_IDLE) begin
                if (bus.IMem_Ack) begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end else begin
                    state_reg <= ST_DROP;
                end
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (room_next) begin
                        state_reg <= ST_FETCH;
                        req_reg   <= 1'b1;
                        addr_reg  <= pc_reg;
                    end
                end
                ST_FETCH: begin
                    if (bus.IMem_Ack) begin
                        pc_reg <= pc_inc;
                        if (room_next) begin
                            addr_reg <= pc_inc;
                        end else begin
                            state_reg <= ST_IDLE;
                            req_reg   <= 1'b0;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.IMem_Ack) begin
                        state_reg <= ST_IDLE;
                        req_reg   <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IMem_Req    = req_reg;
    assign bus.IMem_Addr   = addr_reg;
    assign bus.Instr       = head_data[INSTR_W-1:0];
    assign bus.Instr_PC    = head_data[ENTRY_W-1:INSTR_W];
    assign bus.Instr_Valid = head_valid;

endmodule

// File: doc/ifstage_prefetch.md
# ifstage_prefetch

Instruction fetch stage with a small prefetch queue. Drives the instruction-memory request/acknowledge interface, keeps the PC, and buffers fetched words with their addresses. Presents them to the decode stage over a valid/ready handshake. A redirect from decode/execute (branch or jump) flushes the queue, discards any in-flight fetch and restarts at the target address.

## Interface
Parameters:
- DEPTH, 2 — prefetch queue entries; legal values 2–8.
- RESET_PC, 32'h0000_0000 — PC value loaded on reset.

Ports:
- Clk  in  1  — single clock, rising edge.
- Reset  in  1  — synchronous, active-high reset (sampled on rising Clk).
- IMem_Req  out  1  — fetch request.
- IMem_Addr  out  32  — fetch address, word aligned.
- IMem_Ack  in  1  — memory accepted the request; IMem_Data is valid in the same cycle.
- IMem_Data  in  32  — fetched instruction word.
- Instr  out  32  — instruction at queue head; feeds the decode stage Instr input.
- Instr_PC  out  32  — address of Instr.
- Instr_Valid  out  1  — queue head is valid.
- Instr_Ready  in  1  — decode accepts the head this cycle.
- Redirect  in  1  — one-cycle pulse: flush and refetch.
- Redirect_Target  in  32  — new PC, already computed by the requester; bits [1:0] are ignored and forced to 0.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - FETCH: request outstanding for the current PC.
  - DROP: request outstanding whose result is to be discarded.
- Memory protocol:
  - IMem_Req = (state != IDLE).
  - IMem_Addr = PC in FETCH; in DROP, the address latched at the time of the redirect.
  - Req and Addr stay stable until the cycle IMem_Ack = 1.
- Queue:
  - count in 0..DEPTH. Instr_Valid = (count != 0). Instr and Instr_PC are the head entry.
  - Pop happens when Instr_Valid & Instr_Ready.
  - Push of {PC, IMem_Data} happens on IMem_Ack in FETCH.
  - Simultaneous push and pop is legal at any count, including count = DEPTH.
  - count_next = count + push − pop.
- Transitions (no Redirect):
  - IDLE → FETCH when count_next < DEPTH.
  - FETCH with Ack: PC ← PC+4. Stay in FETCH if count_next < DEPTH, else go to IDLE.
  - FETCH without Ack: hold.
  - DROP with Ack: go to IDLE; the data is discarded and nothing is pushed.
- Redirect (takes priority over every other event in that cycle):
  - Queue emptied (count ← 0); any pop that cycle is ignored.
  - PC ← {Redirect_Target[31:2], 2'b00}.
  - In FETCH without Ack: → DROP. In FETCH with Ack: data discarded, → IDLE.
  - In DROP without Ack: stay in DROP. In DROP with Ack: → IDLE.
  - In IDLE: stay in IDLE.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- Reset during any state: the outstanding request is abandoned. Memory must also be reset by the same Reset.

## Timing
- Reset values:
  - PC = RESET_PC; state IDLE; count 0.
  - IMem_Req = 0, Instr_Valid = 0.
  - Instr and Instr_PC = 0.
- First fetch:
  - Cycle after Reset deasserts: IDLE → FETCH decision at the edge.
  - IMem_Req is high in the next cycle.
- Fetch-to-decode latency:
  - Data acked in cycle N appears with Instr_Valid = 1 in cycle N+1.
- Throughput: with zero-wait memory (Ack in the same cycle as Req) and Instr_Ready held at 1, one instruction per cycle.
- Redirect in cycle N:
  - Instr_Valid = 0 in N+1.
  - Request to the target at the earliest in N+2, after any DROP completes.
- Outputs are registered or driven from registers only. There is no combinational path from Instr_Ready or Redirect to IMem_Req or IMem_Addr.

## Structure
- The shared package (with the processor's other stage definitions) holds:
  - FSM state typedef (IDLE, FETCH, DROP);
  - INSTR_W = 32;
  - PC_INC = 4;
  - default RESET_PC.
- One sub-module: instr_fifo. It is a synchronous DEPTH-entry FIFO of 64-bit {PC, Instr} entries with push/pop/flush and count, and it supports simultaneous push and pop when full.
- The FSM and PC register are in ifstage_prefetch itself.

## Test plan
- Reset, then zero-wait memory returning Data = Addr ^ 32'hA5A5_A5A5, Instr_Ready = 1 → Instr_PC sequence 0, 4, 8, 12 on consecutive cycles, each Instr matching.
- Instr_Ready = 0 for 10 cycles → exactly DEPTH words queued, IMem_Req = 0. Release Ready → words drain in order, no gap and no duplicate.
- Memory acks 3 cycles after each Req → IMem_Addr held stable during the wait, one push per Ack.
- Redirect to 32'h0000_0100 while FETCH of 0x8 is waiting → 0x8 data (acked later) is never presented. Next Instr_Valid carries Instr_PC = 0x100. Queue is empty in the cycle after Redirect.
- Redirect coinciding with Ack, and Redirect coinciding with a pop at count = DEPTH → no push, count = 0, next fetch at the target. Target 32'h0000_0103 fetches 0x100.
- RESET_PC = 32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000. Reset asserted mid-FETCH → IMem_Req = 0 and Instr_Valid = 0 in the next cycle.
